// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: FSM states, opcodes, id class codes, strobe bundle.
package instr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_I,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] ID_ALU  = 3'b000;
  localparam logic [2:0] ID_LD   = 3'b010;
  localparam logic [2:0] ID_ST   = 3'b001;
  localparam logic [2:0] ID_JMP  = 3'b011;
  localparam logic [2:0] ID_BR   = 3'b100;
  localparam logic [2:0] ID_HALT = 3'b111;
  localparam logic [2:0] ID_ILL  = 3'b110;

  typedef struct packed {
    logic pc_read;
    logic mem_read;
    logic reg_write;
    logic alu_ctrl;
    logic is_store;
    logic mem_write;
    logic busy;
    logic halted;
  } ctl_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Fetch bus plus datapath control bundle between the sequencer (master) and memory/datapath (slave).
interface instr_sequencer_if #(
  parameter int INSTR_W = 18,
  parameter int PC_W    = 10
);
  logic [PC_W-1:0]    pc;
  logic               pc_read;
  logic [INSTR_W-1:0] instr_rdata;
  logic               instr_valid;
  logic               dmem_ready;
  logic               alu_zero;
  logic [2:0]         id;
  logic               mem_read;
  logic               reg_write;
  logic               alu_ctrl;
  logic               is_store;
  logic               mem_write;
  logic               clk_cnt_en;
  logic               busy;
  logic               halted;

  modport master (
    output pc, pc_read, id, mem_read, reg_write, alu_ctrl, is_store, mem_write,
           clk_cnt_en, busy, halted,
    input  instr_rdata, instr_valid, dmem_ready, alu_zero
  );

  modport slave (
    input  pc, pc_read, id, mem_read, reg_write, alu_ctrl, is_store, mem_write,
           clk_cnt_en, busy, halted,
    output instr_rdata, instr_valid, dmem_ready, alu_zero
  );
endinterface

// File: rtl/instr_sequencer_opcode_classifier.sv
// Combinational opcode-to-class decode; zero latency, no handshake.
module opcode_classifier
  import instr_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] id
);
  always_comb begin
    id = ID_ILL;
    if (opcode <= 4'd4) begin
      id = ID_ALU;
    end else begin
      case (opcode)
        OP_LD:   id = ID_LD;
        OP_ST:   id = ID_ST;
        OP_JMP:  id = ID_JMP;
        OP_BEQ:  id = ID_BR;
        OP_HALT: id = ID_HALT;
        default: id = ID_ILL;
      endcase
    end
  end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer; 4-6 cycles per instruction, stalls in WAIT_I/MEM on memory handshakes.
// Optional INSTR_SEQ_PERF_EN adds a saturating 16-bit retired-instruction counter.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int INSTR_W  = 18,
  parameter int PC_W     = 10,
  parameter int BR_OFF_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  instr_sequencer_if.master bus
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, br_off;
  logic [3:0]      ir_op_q, ir_op_nxt;
  logic [PC_W-1:0] ir_arg_q, ir_arg_nxt;
  logic [2:0]      id_q, id_nxt, op_id;
  ctl_t            ctl_q, ctl_nxt;
  logic            retire;

  // Only the opcode and the low operand field are ever consumed, so only those are kept.
  opcode_classifier u_cls (
    .opcode (ir_op_q),
    .id     (op_id)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign br_off = {{(PC_W-BR_OFF_W){ir_arg_q[BR_OFF_W-1]}}, ir_arg_q[BR_OFF_W-1:0]};

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    ir_op_nxt  = ir_op_q;
    ir_arg_nxt = ir_arg_q;
    id_nxt     = id_q;
    retire     = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt = ST_FETCH;
          pc_nxt    = '0;
        end
      end
      ST_FETCH: state_nxt = ST_WAIT_I;
      ST_WAIT_I: begin
        if (bus.instr_valid) begin
          ir_op_nxt  = bus.instr_rdata[INSTR_W-1 -: 4];
          ir_arg_nxt = bus.instr_rdata[PC_W-1:0];
          state_nxt  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        id_nxt    = op_id;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (id_q)
          ID_ALU:       state_nxt = ST_WB;
          ID_LD, ID_ST: state_nxt = ST_MEM;
          ID_JMP: begin
            pc_nxt    = ir_arg_q;
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
          ID_BR: begin
            pc_nxt    = bus.alu_zero ? pc_q + br_off : pc_inc;
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
          ID_HALT: state_nxt = ST_HALT;
          default: begin
            pc_nxt    = pc_inc;
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (bus.dmem_ready) begin
          if (id_q == ID_LD) begin
            state_nxt = ST_WB;
          end else begin
            pc_nxt    = pc_inc;
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
        end
      end
      ST_WB: begin
        pc_nxt    = pc_inc;
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Strobes are decoded from the upcoming state so they come straight out of flops.
    ctl_nxt           = '0;
    ctl_nxt.pc_read   = (state_nxt == ST_FETCH) || (state_nxt == ST_WAIT_I);
    ctl_nxt.alu_ctrl  = (state_nxt == ST_EXEC) &&
                        (id_nxt == ID_ALU || id_nxt == ID_LD || id_nxt == ID_ST || id_nxt == ID_BR);
    ctl_nxt.mem_read  = (state_nxt == ST_MEM) && (id_nxt == ID_LD);
    ctl_nxt.is_store  = (state_nxt == ST_MEM) && (id_nxt == ID_ST);
    ctl_nxt.mem_write = (state_nxt == ST_MEM) && (id_nxt == ID_ST);
    ctl_nxt.reg_write = (state_nxt == ST_WB);
    ctl_nxt.busy      = (state_nxt != ST_IDLE) && (state_nxt != ST_HALT);
    ctl_nxt.halted    = (state_nxt == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc_q     <= '0;
      ir_op_q  <= '0;
      ir_arg_q <= '0;
      id_q     <= ID_ALU;
      ctl_q    <= '0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      ir_op_q  <= ir_op_nxt;
      ir_arg_q <= ir_arg_nxt;
      id_q     <= id_nxt;
      ctl_q    <= ctl_nxt;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.id         = id_q;
  assign bus.pc_read    = ctl_q.pc_read;
  assign bus.mem_read   = ctl_q.mem_read;
  assign bus.reg_write  = ctl_q.reg_write;
  assign bus.alu_ctrl   = ctl_q.alu_ctrl;
  assign bus.is_store   = ctl_q.is_store;
  assign bus.mem_write  = ctl_q.mem_write;
  assign bus.busy       = ctl_q.busy;
  assign bus.clk_cnt_en = ctl_q.busy;
  assign bus.halted     = ctl_q.halted;

`ifdef INSTR_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (start && (state == ST_IDLE || state == ST_HALT)) begin
      retired_cnt <= '0;
    end else if (retire && retired_cnt != 16'hFFFF) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle instruction sequencer for the term-project CPU.
- Issues the fetch address and captures the instruction word. Decodes the opcode into the 3-bit class code id[2:0].
- Drives the per-phase control strobes the datapath consumes: PC read, data-memory read, register write, ALU control, store, memory write, clock-counter enable.
- Sits between instruction memory and the datapath. It is the producer of the id/control-signal set that the control FSM decodes.

Parameters:
- INSTR_W, 18, instruction word width; opcode = instr[INSTR_W-1 -: 4].
- PC_W, 10, program-counter / instruction-address width.
- BR_OFF_W, 6, signed branch offset width, taken from instr[BR_OFF_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; leaves IDLE/HALT and begins fetching at PC 0.
- instr_rdata  in  INSTR_W  instruction memory read data.
- instr_valid  in  1  instruction memory response valid.
- dmem_ready  in  1  data memory has completed the load or store.
- alu_zero  in  1  ALU zero flag, sampled in EXECUTE.
- pc  out  PC_W  current instruction address.
- pc_read  out  1  instruction fetch request.
- id  out  3  decoded class: 000 ALU, 010 LOAD, 001 STORE, 011 JUMP, 100 BRANCH, 111 HALT, 110 ILLEGAL.
- mem_read  out  1  data memory read strobe.
- reg_write  out  1  register-file write strobe.
- alu_ctrl  out  1  ALU operation enable.
- is_store  out  1  store path select.
- mem_write  out  1  data memory write strobe.
- clk_cnt_en  out  1  clock counter enable.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset (asynchronous): state=IDLE, pc=0, id=000, instruction register=0. All strobes, busy and halted are 0.
- States:
  - IDLE: wait for start, then go to FETCH.
  - FETCH: pc_read=1 for one cycle, then go to WAIT_I.
  - WAIT_I: hold pc_read=1 until instr_valid. On instr_valid, capture instr_rdata and go to DECODE.
  - DECODE: register id from the opcode. 0x0-0x4 give ALU; 0x5 LOAD; 0x6 STORE; 0x7 JUMP; 0x8 BRANCH; 0xF HALT; all others ILLEGAL. Go to EXEC.
  - EXEC: depends on class.
    - ALU: alu_ctrl=1, then go to WB.
    - LOAD: alu_ctrl=1 (address calculation), then go to MEM.
    - STORE: alu_ctrl=1, then go to MEM.
    - JUMP: pc <= instr[PC_W-1:0], then go to FETCH.
    - BRANCH: alu_ctrl=1. If alu_zero, pc <= pc + sign-extended offset; else pc <= pc+1. Go to FETCH.
    - HALT: go to HALT.
    - ILLEGAL: treated as NOP; pc <= pc+1, go to FETCH.
  - MEM:
    - LOAD: hold mem_read=1 until dmem_ready, then go to WB.
    - STORE: hold is_store=1 and mem_write=1 until dmem_ready. Then pc <= pc+1 and go to FETCH.
  - WB: reg_write=1 for exactly one cycle; pc <= pc+1; go to FETCH.
  - HALT: halted=1; stay until start, which restarts at pc=0.
- Strobes are registered outputs, asserted during the state named above and 0 elsewhere.
- clk_cnt_en=1 in every state except IDLE and HALT, i.e. equal to busy.
- id holds its value from DECODE until the next DECODE.
- Arithmetic:
  - pc wraps modulo 2^PC_W; pc+1 from all-ones gives 0.
  - Branch offset arithmetic also wraps modulo 2^PC_W.
- Latency: with instr_valid asserted the cycle after the FETCH request and dmem_ready immediate:
  - ALU: 5 cycles (FETCH, WAIT_I, DECODE, EXEC, WB).
  - LOAD: 6 cycles.
  - STORE: 5 cycles.
  - JUMP / BRANCH: 4 cycles.
- start while busy is ignored.
- instr_valid outside WAIT_I is ignored; dmem_ready outside MEM is ignored.
- Reset asserted mid-instruction returns the block immediately to the reset state; no strobe survives.

Optional Feature:
- Macro: INSTR_SEQ_PERF_EN.
- Defined: adds output retired_cnt (16-bit). It increments on each WB exit, STORE completion, JUMP/BRANCH exit and ILLEGAL exit. It clears on rst and on start, and saturates at 0xFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package instr_seq_pkg holds:
  - the state enum;
  - the opcode constants (OP_LD=5, OP_ST=6, OP_JMP=7, OP_BEQ=8, OP_HALT=15);
  - the id class constants.
- One sub-module, opcode_classifier: combinational, 4-bit opcode to 3-bit id. The bench reuses it as its reference model.

Test Plan:
- ALU op: instr 0x04000 (opcode 1) at pc 0 → id=000; alu_ctrl high 1 cycle; reg_write high 1 cycle; pc becomes 1; 5 cycles start-to-FETCH.
- LOAD with dmem_ready delayed 3 cycles → mem_read high exactly 3 cycles, then reg_write 1 cycle; id=010.
- STORE → is_store and mem_write high together until dmem_ready; reg_write never asserted; id=001.
- BRANCH, offset 6'b111110, pc=5: alu_zero=1 → pc=3; alu_zero=0 → pc=6. JUMP to 0x3FF, then an ALU op there → pc wraps to 0.
- HALT opcode → halted=1, busy=0, clk_cnt_en=0. A later start → pc=0, FETCH. Opcode 0xA → id=110, pc+1, no strobes besides pc_read.
- rst asserted mid-MEM of a LOAD → all outputs 0 in the same cycle and state IDLE. With INSTR_SEQ_PERF_EN, retired_cnt=0 after rst.
